stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch prescaler counter (sec_counter). It turns raw start/stop, clear and lap buttons into the 2-bit counter command en (00 reset, 01 count, 10 hold) and detects the prescaler terminal count to produce a one-cycle tick. It keeps elapsed seconds and minutes and provides a lap-freeze display path. It sits between the button inputs and the prescaler/display logic.

Parameters:
CNT_W, 19, width of the prescaler count input.
TICK_MAX, 499999, prescaler terminal count; tick period is TICK_MAX+1 clk cycles.
MIN_MAX, 99, last minute value before minutes wrap to 0.

Ports:
clk  input  1  system clock, all flops on rising edge
hard_reset  input  1  asynchronous, active-high reset
btn_start_stop  input  1  raw level, asynchronous to clk
btn_clear  input  1  raw level, asynchronous to clk
btn_lap  input  1  raw level, asynchronous to clk
sec_count  input  CNT_W  current prescaler count
en  output  2  prescaler command: 00 reset, 01 count, 10 hold
tick  output  1  one-cycle pulse at prescaler terminal count while running
sec_val  output  6  live elapsed seconds, 0..59
min_val  output  7  live elapsed minutes, 0..MIN_MAX
disp_sec  output  6  display seconds: live value, or lap-captured value when frozen
disp_min  output  7  display minutes: live value, or lap-captured value when frozen
running  output  1  high in RUN
lap_frozen  output  1  high while the display is frozen

Behaviour:
- Reset (hard_reset=1, takes effect immediately, async): all synchronizer flops 0, state IDLE, sec_val=0, min_val=0, lap registers 0, lap_frozen=0, so en=00, tick=0, running=0.
- Input conditioning, per button: 2-flop synchronizer, then a third flop; event = sync_out & ~delayed. Each press gives one 1-cycle event; a held button gives no repeats. No debounce (handled upstream).
- Latency: if a button is first sampled high at edge N, the event is high during cycle N+2..N+3 and state/counter registers update at edge N+3.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: en=00. start_stop event goes to RUN. clear and lap are ignored.
  - RUN: en=01, except en=00 in any cycle where sec_count==TICK_MAX (combinational), so the prescaler wraps to 0 with no reliance on its own wrap logic. start_stop event goes to PAUSE. clear is ignored. lap event toggles lap_frozen.
  - PAUSE: en=10. start_stop event goes to RUN. clear event goes to IDLE, clears sec_val, min_val and lap_frozen. lap is ignored.
  - Simultaneous start_stop and clear in PAUSE: clear wins, next state IDLE.
- tick = running & (sec_count==TICK_MAX). It is combinational and one cycle wide.
- On tick, at the same edge:
  - sec_val increments.
  - When sec_val is 59, it goes to 0 and min_val increments.
  - When min_val is MIN_MAX and sec_val is 59, both go to 0 (wrap to 00:00).
- If a tick and a start_stop event occur in the same RUN cycle, the tick still counts and the state goes to PAUSE.
- Lap freeze: on the edge where lap_frozen goes 0→1, lap registers capture the post-update sec_val/min_val. This includes a tick in that same cycle.
  - disp_* = lap registers while lap_frozen=1, otherwise live values.
  - The live count continues while frozen.
  - The 1→0 toggle releases the display and leaves the lap registers unchanged.
- Leaving RUN for PAUSE keeps lap_frozen unchanged. Only clear or reset releases the freeze.
- Pulling the prescaler reset (en=00 in IDLE) clears only the prescaler. sec/min clear only on clear or reset.

Test Plan:
(Directed tests use TICK_MAX=9, MIN_MAX=2.)
1. Reset then idle 20 cycles → en=00, sec_val=0, min_val=0, tick=0, running=0. Assert hard_reset mid-RUN → outputs return to reset values before the next clk edge.
2. Pulse start_stop, first sampled high at edge N → en=01 from edge N+3. With sec_count fed from a model prescaler, tick fires every 10 cycles, en=00 on each tick cycle, and sec_val increments 0→1→2.
3. Run 60 ticks → sec_val wraps 59→0 and min_val=1. Run to 2:59 plus one tick → 0:00.
4. In RUN at 0:07, press lap → lap_frozen=1, disp_sec stays 7 while sec_val reaches 12. Press lap again → disp_sec=12, following live.
5. start_stop in RUN → en=10, and sec_val is stable for 50 cycles even with sec_count==9. start_stop again → RUN resumes from the same value.
6. In PAUSE, start_stop and clear pressed in the same cycle → IDLE, en=00, sec_val=min_val=0, lap_frozen=0. clear pressed in RUN → no state change.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button, prescaler and display signals of the stopwatch sequencing controller.
// master drives buttons and the prescaler count; slave is the controller.
interface stopwatch_ctrl_if #(
    parameter int CNT_W = 19
);
    logic             btn_start_stop;
    logic             btn_clear;
    logic             btn_lap;
    logic [CNT_W-1:0] sec_count;
    logic [1:0]       en;
    logic             tick;
    logic [5:0]       sec_val;
    logic [6:0]       min_val;
    logic [5:0]       disp_sec;
    logic [6:0]       disp_min;
    logic             running;
    logic             lap_frozen;

    modport master (
        output btn_start_stop, btn_clear, btn_lap, sec_count,
        input  en, tick, sec_val, min_val, disp_sec, disp_min, running, lap_frozen
    );

    modport slave (
        input  btn_start_stop, btn_clear, btn_lap, sec_count,
        output en, tick, sec_val, min_val, disp_sec, disp_min, running, lap_frozen
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: conditions raw buttons, commands the prescaler, keeps the
// elapsed seconds/minutes and provides a lap-freeze display path.
module stopwatch_ctrl #(
    parameter int CNT_W    = 19,
    parameter int TICK_MAX = 499999,
    parameter int MIN_MAX  = 99
) (
    input logic             clk,
    input logic             hard_reset,
    stopwatch_ctrl_if.slave bus
);

    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;
    localparam int BTN_LAP = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    logic [2:0] btn_raw_s;
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;
    logic [2:0] dly_r;
    logic [2:0] evt_r;

    state_t     state_r;
    logic       running_r;
    logic [1:0] en_base_r;
    logic       lap_frozen_r;
    logic [5:0] sec_r;
    logic [6:0] min_r;
    logic [5:0] lap_sec_r;
    logic [6:0] lap_min_r;

    logic       at_tc_s;
    logic       tick_s;
    logic [5:0] sec_nxt_s;
    logic [6:0] min_nxt_s;
    logic [1:0] en_s;
    logic [5:0] disp_sec_s;
    logic [6:0] disp_min_s;

    assign btn_raw_s = {bus.btn_lap, bus.btn_clear, bus.btn_start_stop};

    // Two-flop synchronizer, delay flop and registered rising-edge event per button
    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            dly_r   <= 3'b000;
            evt_r   <= 3'b000;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
            evt_r   <= sync2_r & ~dly_r;
        end
    end

    assign at_tc_s = (bus.sec_count == CNT_W'(TICK_MAX));
    assign tick_s  = running_r & at_tc_s;

    // Time value after this cycle's tick, if any; minutes wrap after MIN_MAX:59
    always_comb begin
        sec_nxt_s = sec_r;
        min_nxt_s = min_r;
        if (tick_s) begin
            if (sec_r == 6'd59) begin
                sec_nxt_s = 6'd0;
                if (min_r == 7'(MIN_MAX)) begin
                    min_nxt_s = 7'd0;
                end else begin
                    min_nxt_s = min_r + 7'd1;
                end
            end else begin
                sec_nxt_s = sec_r + 6'd1;
                min_nxt_s = min_r;
            end
        end else begin
            sec_nxt_s = sec_r;
            min_nxt_s = min_r;
        end
    end

    // Sequencer with registered prescaler command, time base and lap capture
    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state_r      <= ST_IDLE;
            running_r    <= 1'b0;
            en_base_r    <= 2'b00;
            lap_frozen_r <= 1'b0;
            sec_r        <= 6'd0;
            min_r        <= 7'd0;
            lap_sec_r    <= 6'd0;
            lap_min_r    <= 7'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (evt_r[BTN_SS]) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        en_base_r <= 2'b01;
                    end
                end
                ST_RUN: begin
                    sec_r <= sec_nxt_s;
                    min_r <= min_nxt_s;
                    // Capture the post-tick value so a lap on a tick edge shows the new second
                    if (evt_r[BTN_LAP]) begin
                        lap_frozen_r <= ~lap_frozen_r;
                        if (!lap_frozen_r) begin
                            lap_sec_r <= sec_nxt_s;
                            lap_min_r <= min_nxt_s;
                        end
                    end
                    if (evt_r[BTN_SS]) begin
                        state_r   <= ST_PAUSE;
                        running_r <= 1'b0;
                        en_base_r <= 2'b10;
                    end
                end
                ST_PAUSE: begin
                    if (evt_r[BTN_CLR]) begin
                        state_r      <= ST_IDLE;
                        running_r    <= 1'b0;
                        en_base_r    <= 2'b00;
                        sec_r        <= 6'd0;
                        min_r        <= 7'd0;
                        lap_frozen_r <= 1'b0;
                    end else if (evt_r[BTN_SS]) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        en_base_r <= 2'b01;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                    en_base_r <= 2'b00;
                end
            endcase
        end
    end

    // Force a prescaler reset on the terminal count so it never depends on its own wrap
    always_comb begin
        if (tick_s) begin
            en_s = 2'b00;
        end else begin
            en_s = en_base_r;
        end
    end

    // Display path: frozen lap value or live time
    always_comb begin
        if (lap_frozen_r) begin
            disp_sec_s = lap_sec_r;
            disp_min_s = lap_min_r;
        end else begin
            disp_sec_s = sec_r;
            disp_min_s = min_r;
        end
    end

    assign bus.en         = en_s;
    assign bus.tick       = tick_s;
    assign bus.sec_val    = sec_r;
    assign bus.min_val    = min_r;
    assign bus.disp_sec   = disp_sec_s;
    assign bus.disp_min   = disp_min_s;
    assign bus.running    = running_r;
    assign bus.lap_frozen = lap_frozen_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: an elapsed-seconds reference model drives a model prescaler
// and every check compares the DUT against it or against directed constants.
module tb_stopwatch_ctrl;

    localparam int CNT_W    = 4;
    localparam int TICK_MAX = 9;
    localparam int MIN_MAX  = 2;
    localparam int WRAP     = 60 * (MIN_MAX + 1);

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mmode_t;

    logic clk;
    logic hard_reset;
    logic [CNT_W-1:0] pcount;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl_if #(.CNT_W(CNT_W)) sw_if ();

    stopwatch_ctrl #(
        .CNT_W   (CNT_W),
        .TICK_MAX(TICK_MAX),
        .MIN_MAX (MIN_MAX)
    ) dut (
        .clk       (clk),
        .hard_reset(hard_reset),
        .bus       (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sw_if.sec_count = pcount;

    // Reference model: mode, elapsed seconds as one integer, lap snapshot
    mmode_t     m_mode    = M_IDLE;
    int         m_elapsed = 0;
    int         m_lap     = 0;
    bit         m_frozen  = 1'b0;
    bit [2:0]   m_prev    = 3'b000;
    bit [2:0]   m_p0      = 3'b000;
    bit [2:0]   m_p1      = 3'b000;
    bit [2:0]   m_p2      = 3'b000;
    bit [2:0]   btn_now;
    mmode_t     n_mode;
    int         n_el;
    int         n_lap;
    bit         n_fr;
    logic [CNT_W-1:0] n_pc;

    assign btn_now = {sw_if.btn_lap, sw_if.btn_clear, sw_if.btn_start_stop};

    always_comb begin
        n_mode = m_mode;
        n_el   = m_elapsed;
        n_lap  = m_lap;
        n_fr   = m_frozen;
        n_pc   = pcount;
        if (m_mode == M_IDLE) n_pc = '0;
        else if (m_mode == M_PAUSE) n_pc = pcount;
        else if (pcount == CNT_W'(TICK_MAX)) n_pc = '0;
        else n_pc = pcount + 1'b1;
        // a press seen at edge E acts at edge E+3 (p2 holds it then)
        case (m_mode)
            M_RUN: begin
                if (pcount == CNT_W'(TICK_MAX)) n_el = (m_elapsed + 1) % WRAP;
                if (m_p2[2]) begin
                    n_fr = !m_frozen;
                    if (!m_frozen) n_lap = n_el;
                end
                if (m_p2[0]) n_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (m_p2[1]) begin
                    n_mode = M_IDLE;
                    n_el   = 0;
                    n_fr   = 1'b0;
                end else if (m_p2[0]) begin
                    n_mode = M_RUN;
                end
            end
            default: begin
                if (m_p2[0]) n_mode = M_RUN;
            end
        endcase
    end

    always @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            m_mode    <= M_IDLE;
            m_elapsed <= 0;
            m_lap     <= 0;
            m_frozen  <= 1'b0;
            m_prev    <= 3'b000;
            m_p0      <= 3'b000;
            m_p1      <= 3'b000;
            m_p2      <= 3'b000;
            pcount    <= '0;
        end else begin
            m_mode    <= n_mode;
            m_elapsed <= n_el;
            m_lap     <= n_lap;
            m_frozen  <= n_fr;
            m_prev    <= btn_now;
            m_p0      <= btn_now & ~m_prev;
            m_p1      <= m_p0;
            m_p2      <= m_p1;
            pcount    <= n_pc;
        end
    end

    function automatic logic [30:0] exp_vec();
        logic [1:0] e;
        logic       t;
        int         ds;
        t = (m_mode == M_RUN) && (pcount == CNT_W'(TICK_MAX));
        if (m_mode == M_IDLE) e = 2'b00;
        else if (m_mode == M_PAUSE) e = 2'b10;
        else if (t) e = 2'b00;
        else e = 2'b01;
        ds = m_frozen ? m_lap : m_elapsed;
        return {e, t, 6'(m_elapsed % 60), 7'(m_elapsed / 60), 6'(ds % 60), 7'(ds / 60),
                (m_mode == M_RUN), m_frozen};
    endfunction

    logic [30:0] dut_vec;
    assign dut_vec = {sw_if.en, sw_if.tick, sw_if.sec_val, sw_if.min_val, sw_if.disp_sec,
                      sw_if.disp_min, sw_if.running, sw_if.lap_frozen};

    task automatic press(input bit ss, input bit clr, input bit lap);
        sw_if.btn_start_stop = ss;
        sw_if.btn_clear      = clr;
        sw_if.btn_lap        = lap;
        @(negedge clk);
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        sw_if.btn_lap        = 1'b0;
    endtask

    task automatic test_reset();
        hard_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec !== 31'd0) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", dut_vec, 31'd0);
        end
        hard_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec() || sw_if.en !== 2'b00 || sw_if.sec_val !== 6'd0) begin
                n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_start_tick();
        press(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (sw_if.en !== 2'b00) begin
            n_fail++; $display("FAIL start_early: got en=%b expected en=00", sw_if.en);
        end
        @(negedge clk);
        n_checks++;
        if (sw_if.en !== 2'b01 || sw_if.running !== 1'b1) begin
            n_fail++; $display("FAIL start_latency: got en=%b run=%b expected en=01 run=1",
                               sw_if.en, sw_if.running);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL tick_count: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        int  prev_el = m_elapsed;
        bit  seen_min = 1'b0;
        bit  seen_wrap = 1'b0;
        for (int i = 0; i < 1900; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL wrap_run: got %h expected %h", dut_vec, exp_vec());
            end
            if (m_elapsed == 60 && prev_el == 59) begin
                seen_min = 1'b1;
                n_checks++;
                if (sw_if.sec_val !== 6'd0 || sw_if.min_val !== 7'd1) begin
                    n_fail++; $display("FAIL sec_wrap: got %0d:%0d expected 1:0",
                                       sw_if.min_val, sw_if.sec_val);
                end
            end
            if (m_elapsed == 0 && prev_el == WRAP - 1) begin
                seen_wrap = 1'b1;
                n_checks++;
                if (sw_if.sec_val !== 6'd0 || sw_if.min_val !== 7'd0) begin
                    n_fail++; $display("FAIL min_wrap: got %0d:%0d expected 0:0",
                                       sw_if.min_val, sw_if.sec_val);
                end
            end
            prev_el = m_elapsed;
        end
        n_checks++;
        if (!(seen_min && seen_wrap)) begin
            n_fail++; $display("FAIL wrap_reached: got %0d%0d expected 11", seen_min, seen_wrap);
        end
    endtask

    task automatic test_lap();
        int budget = 0;
        while (!(m_mode == M_RUN && (m_elapsed % 60) == 7 && pcount == '0) && budget < 800) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (budget >= 800) begin
            n_fail++; $display("FAIL lap_wait: got timeout expected sec 7");
        end
        press(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 55; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec() || (m_frozen && sw_if.disp_sec !== 6'd7)) begin
                n_fail++; $display("FAIL lap_freeze: got %h expected %h", dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (sw_if.sec_val !== 6'd12 || sw_if.lap_frozen !== 1'b1) begin
            n_fail++; $display("FAIL lap_live: got sec=%0d frz=%b expected sec=12 frz=1",
                               sw_if.sec_val, sw_if.lap_frozen);
        end
        press(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec() || (!m_frozen && sw_if.disp_sec !== 6'(m_elapsed % 60))) begin
                n_fail++; $display("FAIL lap_release: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_pause();
        int budget = 0;
        logic [5:0] hold_sec;
        while (!(m_mode == M_RUN && pcount == 4'd5) && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        press(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        hold_sec = 6'(m_elapsed % 60);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec() || sw_if.sec_val !== hold_sec || sw_if.en !== 2'b10 ||
                sw_if.tick !== 1'b0 || pcount !== 4'd9) begin
                n_fail++; $display("FAIL pause_hold: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_resume();
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec() || (i >= 2 && sw_if.running !== 1'b1)) begin
                n_fail++; $display("FAIL resume: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        hard_reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== 31'd0) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec, 31'd0);
        end
        repeat (2) @(negedge clk);
        hard_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_in_run();
        press(1'b1, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec() || sw_if.running !== 1'b1) begin
                n_fail++; $display("FAIL clear_run: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        press(1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        press(1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (sw_if.en !== 2'b10 || sw_if.lap_frozen !== 1'b1) begin
            n_fail++; $display("FAIL pause_frozen: got en=%b frz=%b expected en=10 frz=1",
                               sw_if.en, sw_if.lap_frozen);
        end
        press(1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (sw_if.en !== 2'b00 || sw_if.sec_val !== 6'd0 || sw_if.min_val !== 7'd0 ||
            sw_if.lap_frozen !== 1'b0 || sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL clear_wins: got %h expected en=00 zero time", dut_vec);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL idle_after_clear: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) sw_if.btn_start_stop = ~sw_if.btn_start_stop;
            if ($urandom_range(0, 29) == 0) sw_if.btn_clear = ~sw_if.btn_clear;
            if ($urandom_range(0, 14) == 0) sw_if.btn_lap = ~sw_if.btn_lap;
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        hard_reset           = 1'b1;
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        sw_if.btn_lap        = 1'b0;
        @(negedge clk);
        test_reset();
        test_start_tick();
        test_wrap();
        test_lap();
        test_pause();
        test_resume();
        test_async_reset();
        test_clear_in_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
